// File: rtl/match_sequencer.sv
// match_sequencer: game-flow controller for the Pong datapath.
//
// Walks IDLE -> SERVE -> PLAY -> (SERVE | OVER) -> IDLE. It owns both score
// registers, the serve/game-over delay counter and the winner decision. The
// physics engine and countdown timer are gated through stop/serve_req/timer_run.
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   start             start button level (rising edge acts, IDLE only)
//   miss1, miss2      per-player miss levels (rising edge scores for the other)
//   time_up           countdown timer expired (level)
//   stop              1 = freeze ball and paddles
//   serve_req         one-cycle pulse on every entry to SERVE
//   timer_run         1 = countdown timer may decrement
//   score1, score2    player scores, saturating at 7
//   winner            00 none, 01 player 1, 10 player 2, 11 draw
//   state             IDLE=0, SERVE=1, PLAY=2, OVER=3
module match_sequencer #(
  parameter int unsigned SERVE_CYCLES = 100_000_000,
  parameter int unsigned OVER_CYCLES  = 150_000_000,
  parameter int unsigned WIN_SCORE    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  input  logic       time_up,
  output logic       stop,
  output logic       serve_req,
  output logic       timer_run,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_OVER  = 3'd3
  } state_t;

  localparam logic [31:0] SERVE_LD = 32'(SERVE_CYCLES);
  localparam logic [31:0] OVER_LD  = 32'(OVER_CYCLES);
  localparam logic [2:0]  WIN      = 3'(WIN_SCORE);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  score1_q, score1_d;
  logic [2:0]  score2_q, score2_d;
  logic [1:0]  winner_q, winner_d;
  logic        serve_req_q, serve_req_d;
  logic        start_prev_q, miss1_prev_q, miss2_prev_q;

  logic        start_e, miss1_e, miss2_e;
  logic        go_serve, go_over;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign start_e = start & ~start_prev_q;
  assign miss1_e = miss1 & ~miss1_prev_q;
  assign miss2_e = miss2 & ~miss2_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    serve_req_d = 1'b0;
    go_serve    = 1'b0;
    go_over     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_e) begin
          score1_d = 3'd0;
          score2_d = 3'd0;
          winner_d = 2'b00;
          go_serve = 1'b1;
        end
      end

      S_SERVE: begin
        // time_up wins over the serve countdown; counter == 1 means this is
        // the last of SERVE_CYCLES cycles.
        if (time_up)               go_over = 1'b1;
        else if (cnt_q <= 32'd1)   state_d = S_PLAY;
        else                       cnt_d   = cnt_q - 32'd1;
      end

      S_PLAY: begin
        if (miss1_e && miss2_e) begin
          // simultaneous misses cancel: replay the serve
          if (time_up) go_over  = 1'b1;
          else         go_serve = 1'b1;
        end else if (miss1_e) begin
          score2_d = sat_inc(score2_q);
          if (time_up || score2_d == WIN) go_over  = 1'b1;
          else                            go_serve = 1'b1;
        end else if (miss2_e) begin
          score1_d = sat_inc(score1_q);
          if (time_up || score1_d == WIN) go_over  = 1'b1;
          else                            go_serve = 1'b1;
        end else if (time_up) begin
          go_over = 1'b1;
        end
      end

      S_OVER: begin
        if (cnt_q <= 32'd1) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 32'd1;
      end

      default: state_d = S_IDLE;
    endcase

    if (go_serve) begin
      state_d     = S_SERVE;
      cnt_d       = SERVE_LD;
      serve_req_d = 1'b1;
    end
    // winner is decided from the post-point scores of this same cycle
    if (go_over) begin
      state_d = S_OVER;
      cnt_d   = OVER_LD;
      if (score1_d > score2_d)      winner_d = 2'b01;
      else if (score1_d < score2_d) winner_d = 2'b10;
      else                          winner_d = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      score1_q     <= 3'd0;
      score2_q     <= 3'd0;
      winner_q     <= 2'b00;
      serve_req_q  <= 1'b0;
      start_prev_q <= 1'b0;
      miss1_prev_q <= 1'b0;
      miss2_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      serve_req_q  <= serve_req_d;
      start_prev_q <= start;
      miss1_prev_q <= miss1;
      miss2_prev_q <= miss2;
    end
  end

  // stop/timer_run decode the state register, so they track state exactly
  assign stop      = (state_q != S_PLAY);
  assign timer_run = (state_q == S_PLAY);
  assign serve_req = serve_req_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with SERVE_CYCLES=4, OVER_CYCLES=6,
// WIN_SCORE=3. Inputs change 1 time unit after a rising edge; outputs are
// checked at the same point.
module tb_match_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, miss1, miss2, time_up;
  logic       stop, serve_req, timer_run;
  logic [2:0] score1, score2, state;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;
  int pulses;

  match_sequencer #(.SERVE_CYCLES(4), .OVER_CYCLES(6), .WIN_SCORE(3)) dut (
    .clk(clk), .rst(rst), .start(start), .miss1(miss1), .miss2(miss2),
    .time_up(time_up), .stop(stop), .serve_req(serve_req),
    .timer_run(timer_run), .score1(score1), .score2(score2),
    .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // bounded wait for PLAY
  task automatic wait_state(input string tag, input int want);
    for (int i = 0; i < 20; i++) begin
      if (int'(state) == want) break;
      tick();
    end
    chk(tag, int'(state), want);
  endtask

  task automatic miss_pulse(input bit p1, input bit p2);
    miss1 = p1; miss2 = p2;
    tick();
    miss1 = 1'b0; miss2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0; time_up = 1'b0;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_stop", stop, 1);
    chk("rst_serve_req", serve_req, 0);
    chk("rst_timer_run", timer_run, 0);
    chk("rst_scores", {score1, score2}, 0);
    chk("rst_winner", winner, 0);
    rst = 1'b0;
    tick();
    chk("idle_hold", state, 0);

    // start edge: SERVE for exactly 4 cycles, serve_req on the first only
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      chk($sformatf("serve_state_%0d", i), state, 1);
      chk($sformatf("serve_req_%0d", i), serve_req, (i == 0) ? 1 : 0);
    end
    tick();
    chk("play_state", state, 2);
    chk("play_stop", stop, 0);
    chk("play_timer_run", timer_run, 1);

    // miss1 held 10 cycles: scores once, one serve_req pulse
    miss1 = 1'b1;
    pulses = 0;
    tick();
    chk("m1_state", state, 1);
    chk("m1_score2", score2, 1);
    if (serve_req) pulses++;
    for (int i = 1; i < 10; i++) begin
      tick();
      if (serve_req) pulses++;
    end
    miss1 = 1'b0;
    tick();
    chk("m1_held_score2", score2, 1);
    chk("m1_held_state", state, 2);
    chk("m1_pulses", pulses, 1);

    // simultaneous misses: no score change, back to SERVE
    miss_pulse(1'b1, 1'b1);
    chk("both_state", state, 1);
    chk("both_score1", score1, 0);
    chk("both_score2", score2, 1);
    wait_state("both_replay", 2);

    // player 2 reaches 3
    miss_pulse(1'b1, 1'b0);
    chk("p2_two", score2, 2);
    wait_state("p2_replay", 2);
    miss1 = 1'b1;
    tick();
    miss1 = 1'b0;
    chk("win_state", state, 3);
    chk("win_winner", winner, 2);
    chk("win_stop", stop, 1);
    chk("win_score2", score2, 3);
    // start rises during OVER and is held into IDLE: no restart
    start = 1'b1;
    repeat (5) tick();
    chk("over_hold", state, 3);
    tick();
    chk("over_to_idle", state, 0);
    chk("idle_score2", score2, 3);
    repeat (3) tick();
    chk("held_start_no_restart", state, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_scores", {score1, score2}, 0);
    chk("restart_winner", winner, 0);

    // draw on time_up at 1-1
    wait_state("draw_play0", 2);
    miss_pulse(1'b0, 1'b1);
    chk("draw_s1", score1, 1);
    wait_state("draw_play1", 2);
    miss_pulse(1'b1, 1'b0);
    chk("draw_s2", score2, 1);
    wait_state("draw_play2", 2);
    time_up = 1'b1;
    tick();
    time_up = 1'b0;
    chk("draw_state", state, 3);
    chk("draw_winner", winner, 3);
    wait_state("draw_idle", 0);

    // time_up during SERVE forces OVER
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("tu_serve_entry", state, 1);
    time_up = 1'b1;
    tick();
    time_up = 1'b0;
    chk("tu_serve_over", state, 3);
    chk("tu_serve_winner", winner, 3);
    wait_state("tu_serve_idle", 0);

    // point and time_up together: point scored, then OVER
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state("tu_miss_play0", 2);
    miss_pulse(1'b0, 1'b1);
    wait_state("tu_miss_play1", 2);
    miss2 = 1'b1; time_up = 1'b1;
    tick();
    miss2 = 1'b0; time_up = 1'b0;
    chk("tu_miss_score1", score1, 2);
    chk("tu_miss_state", state, 3);
    chk("tu_miss_winner", winner, 1);
    wait_state("tu_miss_idle", 0);

    // async reset mid-SERVE, then start held through release
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state("rst_play", 2);
    miss2 = 1'b1;
    tick();
    miss2 = 1'b0;
    chk("pre_rst_serve_req", serve_req, 1);
    chk("pre_rst_score1", score1, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_serve_req", serve_req, 0);
    chk("async_rst_score1", score1, 0);
    chk("async_rst_stop", stop, 1);
    start = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("start_through_rst", state, 1);
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
